// File: rtl/rf_pkg.sv
// rf_pkg: shared widths and the queued writeback entry type.
//   AW         register address width
//   DW         register data width
//   wb_entry_t one pending register file write {addr, data}
package rf_pkg;
    localparam int AW = 4;
    localparam int DW = 16;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/rf_wb_fifo.sv
// rf_wb_fifo: 2-push/1-pop circular buffer of writeback entries.
//   clk, rst   clock, synchronous active-low reset
//   push_n     entries to enqueue this cycle (0..2), e0 before e1
//   e0, e1     entries to enqueue
//   pop        dequeue the head entry
//   ent        raw entry storage, indexed by pointer
//   head       index of the oldest entry
//   count      occupied entries, 0..DEPTH
//   vmask      per-slot occupied flag
module rf_wb_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 push_n,
    input  wb_entry_t                  e0,
    input  wb_entry_t                  e1,
    input  logic                       pop,
    output wb_entry_t                  ent [DEPTH],
    output logic [$clog2(DEPTH)-1:0]   head,
    output logic [$clog2(DEPTH):0]     count,
    output logic [DEPTH-1:0]           vmask
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wp;

    always_ff @(posedge clk)
        if (!rst) begin
            wp    <= '0;
            head  <= '0;
            count <= '0;
        end else begin
            if (push_n != 2'd0) ent[wp] <= e0;
            if (push_n == 2'd2) ent[wp + PW'(1)] <= e1;
            wp    <= wp + PW'(push_n);
            head  <= head + PW'(pop);
            count <= count - CW'(pop) + CW'(push_n);
        end

    // A slot is occupied when its distance from head is below count.
    always_comb
        for (int i = 0; i < DEPTH; i++)
            vmask[i] = {1'b0, PW'(PW'(i) - head)} < count;
endmodule

// File: rtl/rf_wb_ctrl.sv
// rf_wb_ctrl: writeback controller, sole writer of the register file.
//   clk, rst                       clock, synchronous active-low reset
//   mem_valid/waddr/data           load result
//   alu_valid/waddr/data           ALU result
//   in_ready                       both paths may present a result
//   WrX, waddr, DataIn             registered register file write port
//   fwd_addr_n / fwd_hit_n / fwd_data_n  forwarding lookups of pending writes
//   ovf                            sticky: result presented while not ready
module rf_wb_ctrl
    import rf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = rf_pkg::AW,
    parameter int DW    = rf_pkg::DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_valid,
    input  logic [AW-1:0] mem_waddr,
    input  logic [DW-1:0] mem_data,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_waddr,
    input  logic [DW-1:0] alu_data,
    output logic          in_ready,
    output logic          WrX,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] DataIn,
    input  logic [AW-1:0] fwd_addr_1,
    input  logic [AW-1:0] fwd_addr_2,
    output logic          fwd_hit_1,
    output logic          fwd_hit_2,
    output logic [DW-1:0] fwd_data_1,
    output logic [DW-1:0] fwd_data_2,
    output logic          ovf
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t        ent [DEPTH];
    wb_entry_t        e0, e1, hd;
    logic [PW-1:0]    head;
    logic [CW-1:0]    count;
    logic [DEPTH-1:0] vmask;
    logic [1:0]       push_n;
    logic             pop;

    assign in_ready = count <= CW'(DEPTH - 2);
    assign pop      = count != '0;
    assign push_n   = in_ready ? {mem_valid & alu_valid, mem_valid ^ alu_valid} : 2'd0;
    // The load is the older instruction, so it goes first when both arrive.
    assign e0       = mem_valid ? '{mem_waddr, mem_data} : '{alu_waddr, alu_data};
    assign e1       = '{alu_waddr, alu_data};
    assign hd       = ent[head];

    rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_n (push_n),
        .e0     (e0),
        .e1     (e1),
        .pop    (pop),
        .ent    (ent),
        .head   (head),
        .count  (count),
        .vmask  (vmask)
    );

    always_ff @(posedge clk)
        if (!rst) begin
            WrX    <= 1'b0;
            waddr  <= '0;
            DataIn <= '0;
            ovf    <= 1'b0;
        end else begin
            WrX <= pop;
            if (pop) begin
                waddr  <= hd.addr;
                DataIn <= hd.data;
            end
            if ((mem_valid || alu_valid) && !in_ready) ovf <= 1'b1;
        end

    // Output register is the oldest pending write; the queue is walked
    // oldest to youngest so the last match left standing is the youngest.
    function automatic logic [DW:0] lookup(input logic [AW-1:0] a);
        logic [DW:0]   r;
        logic [PW-1:0] idx;
        r = (WrX && waddr == a) ? {1'b1, DataIn} : '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (vmask[idx] && ent[idx].addr == a) r = {1'b1, ent[idx].data};
        end
        return r;
    endfunction

    assign {fwd_hit_1, fwd_data_1} = lookup(fwd_addr_1);
    assign {fwd_hit_2, fwd_data_2} = lookup(fwd_addr_2);
endmodule

// File: tb/tb_rf_wb_ctrl.sv
// tb_rf_wb_ctrl: scoreboard bench for rf_wb_ctrl with directed vectors.
module tb_rf_wb_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_valid = 1'b0, alu_valid = 1'b0;
    logic [3:0]  mem_waddr = '0, alu_waddr = '0;
    logic [15:0] mem_data = '0, alu_data = '0;
    logic        in_ready, WrX, ovf;
    logic [3:0]  waddr;
    logic [15:0] DataIn;
    logic [3:0]  fwd_addr_1 = '0, fwd_addr_2 = '0;
    logic        fwd_hit_1, fwd_hit_2;
    logic [15:0] fwd_data_1, fwd_data_2;

    logic [19:0] sb [$];
    logic [15:0] rf [16];
    int          vectors = 0;
    int          miscompares = 0;

    rf_wb_ctrl #(.DEPTH(4), .AW(4), .DW(16)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_waddr(mem_waddr), .mem_data(mem_data),
        .alu_valid(alu_valid), .alu_waddr(alu_waddr), .alu_data(alu_data),
        .in_ready(in_ready), .WrX(WrX), .waddr(waddr), .DataIn(DataIn),
        .fwd_addr_1(fwd_addr_1), .fwd_addr_2(fwd_addr_2),
        .fwd_hit_1(fwd_hit_1), .fwd_hit_2(fwd_hit_2),
        .fwd_data_1(fwd_data_1), .fwd_data_2(fwd_data_2),
        .ovf(ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (WrX) rf[waddr] <= DataIn;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every register file write must match the oldest expected entry.
    always @(negedge clk)
        if (WrX) begin
            if (sb.size() == 0) check("unexpected_write", {12'h0, waddr, DataIn}, 32'hdead_0000);
            else check("write_order", {12'h0, waddr, DataIn}, {12'h0, sb.pop_front()});
        end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic mv, input logic [3:0] ma, input logic [15:0] md,
                         input logic av, input logic [3:0] aa, input logic [15:0] ad,
                         input logic acc);
        check("in_ready", in_ready, acc);
        mem_valid = mv; mem_waddr = ma; mem_data = md;
        alu_valid = av; alu_waddr = aa; alu_data = ad;
        if (acc && mv) sb.push_back({ma, md});
        if (acc && av) sb.push_back({aa, ad});
        tick;
        mem_valid = 1'b0;
        alu_valid = 1'b0;
    endtask

    task automatic check_reset_state;
        check("rst_wrx", WrX, 1'b0);
        check("rst_waddr", waddr, 4'h0);
        check("rst_datain", DataIn, 16'h0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tick; tick;
        check_reset_state;
        rst = 1'b1;
        tick;

        // Single write: WrX only in the cycle after the push edge.
        issue(0, 0, 0, 1, 4'd3, 16'h1234, 1);
        check("lat_wrx_early", WrX, 1'b0);
        tick;
        check("lat_wrx", WrX, 1'b1);
        check("lat_waddr", waddr, 4'd3);
        check("lat_data", DataIn, 16'h1234);
        tick;
        check("lat_wrx_drop", WrX, 1'b0);
        check("rf_r3", rf[3], 16'h1234);

        // Dual push to the same register: alu value is the final one.
        fwd_addr_1 = 4'd5;
        issue(1, 4'd5, 16'h0001, 1, 4'd5, 16'h0002, 1);
        for (int c = 0; c < 3; c++) begin
            check("dual_fwd_hit", fwd_hit_1, 1'b1);
            check("dual_fwd_data", fwd_data_1, 16'h0002);
            tick;
        end
        check("dual_fwd_clear", fwd_hit_1, 1'b0);

        // Forwarding hit on one port, miss on the other.
        fwd_addr_2 = 4'd7;
        fwd_addr_1 = 4'd8;
        issue(0, 0, 0, 1, 4'd7, 16'hbeef, 1);
        check("fwd2_hit", fwd_hit_2, 1'b1);
        check("fwd2_data", fwd_data_2, 16'hbeef);
        check("fwd1_miss", fwd_hit_1, 1'b0);
        check("fwd1_zero", fwd_data_1, 16'h0);
        tick;
        check("fwd2_hit_wrx", fwd_hit_2, 1'b1);
        check("fwd2_wrx", WrX, 1'b1);
        tick;
        check("fwd2_clear", fwd_hit_2, 1'b0);
        check("fwd2_clear_data", fwd_data_2, 16'h0);

        // Backpressure: third dual push sees count 3 and is dropped.
        check("ovf_pre", ovf, 1'b0);
        issue(1, 4'd1, 16'h00a1, 1, 4'd2, 16'h00a2, 1);
        issue(1, 4'd3, 16'h00a3, 1, 4'd4, 16'h00a4, 1);
        issue(1, 4'd9, 16'h0bad, 1, 4'd10, 16'h0bad, 0);
        check("ovf_set", ovf, 1'b1);
        check("ready_back", in_ready, 1'b1);
        repeat (5) tick;
        check("ovf_sticky", ovf, 1'b1);
        check("drained", sb.size(), 0);

        // Mid-drain reset with three entries still queued.
        issue(1, 4'd11, 16'h0b11, 1, 4'd12, 16'h0b12, 1);
        issue(1, 4'd13, 16'h0b13, 1, 4'd14, 16'h0b14, 1);
        rst = 1'b0;
        tick;
        sb.delete();
        check_reset_state;
        tick;
        rst = 1'b1;
        check_reset_state;
        fwd_addr_1 = 4'd12;
        check("rst_fwd_miss", fwd_hit_1, 1'b0);
        repeat (4) tick;
        check("rst_no_write", WrX, 1'b0);

        // Wrap-around: single, dual, idle keeps the queue from filling.
        for (int i = 0; i < 10; i++) begin
            issue(0, 0, 0, 1, 4'(3 * i), 16'ha000 + 16'(3 * i), 1);
            issue(1, 4'(3 * i + 1), 16'ha001 + 16'(3 * i), 1, 4'(3 * i + 2), 16'ha002 + 16'(3 * i), 1);
            tick;
        end
        repeat (6) tick;
        check("wrap_drained", sb.size(), 0);
        check("wrap_ovf_clear", ovf, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rf_wb_ctrl.md
# rf_wb_ctrl

Writeback controller that is the sole writer of the 16x16 register file. Accepts up to two results per cycle (load path and ALU path), queues them in a small in-order buffer, and drains one write per cycle onto the register file write port (WrX/waddr/DataIn). Provides a two-port forwarding lookup so the decode stage can read values that are queued but not yet written.

## Interface

Parameters:
- DEPTH, 4, queue entries; power of two, >= 2
- AW, 4, register address width
- DW, 16, data width

Ports:
- clk  in  1  clock; all state changes on posedge
- rst  in  1  synchronous, active-low reset
- mem_valid  in  1  load result present this cycle
- mem_waddr  in  AW  load destination register
- mem_data  in  DW  load result
- alu_valid  in  1  ALU result present this cycle
- alu_waddr  in  AW  ALU destination register
- alu_data  in  DW  ALU result
- in_ready  out  1  both paths may present results this cycle
- WrX  out  1  register file write enable (registered)
- waddr  out  AW  register file write address (registered)
- DataIn  out  DW  register file write data (registered)
- fwd_addr_1, fwd_addr_2  in  AW  forwarding lookup addresses
- fwd_hit_1, fwd_hit_2  out  1  pending write to that address exists
- fwd_data_1, fwd_data_2  out  DW  youngest pending value for that address
- ovf  out  1  sticky: a valid was presented while in_ready = 0

## Operation

- Queue holds {addr, data} entries not yet driven to the RF; count 0..DEPTH.
- in_ready = (count <= DEPTH-2). Evaluated on the current count, so two pushes are always safe, even with no pop.
- Push when in_ready: if both valid, mem entry enqueued first (older instruction), then alu. A single valid enqueues one entry.
- Valid with in_ready = 0: input dropped, queue unchanged, ovf set; ovf clears only on reset.
- Pop: each cycle with count > 0, head moves into the output register with WrX = 1. With count = 0, WrX = 0 and waddr/DataIn hold their last values.
- Next count = count - pop + pushes. Pointers wrap modulo DEPTH.
- Same-address pushes in one cycle: both written in order; the alu value is final.
- Forwarding (combinational): search the queue youngest-to-oldest, then the output register while WrX = 1. The first match gives hit = 1 and its data. No match gives hit = 0 and data = 0. Same-cycle inputs are not searched. Register 0 has no special treatment.

## Timing

- Reset (rst = 0 at posedge): count = 0, pointers = 0, WrX = 0, waddr = 0, DataIn = 0, ovf = 0, in_ready = 1 after the edge. Queued writes are discarded, including during a mid-drain reset.
- Latency: an entry pushed at edge N into an empty queue is driven at edge N+1, so WrX is high during cycle N+1 and the RF captures it at edge N+2.
- Throughput: one RF write per cycle; sustained dual issue fills the queue, and in_ready deasserts at count > DEPTH-2.
- Forwarding outputs reflect state after the most recent edge; the RF contents become visible to readers only after the write edge, and forwarding covers that gap.

## Structure

- Package rf_pkg: AW, DW constants; typedef wb_entry_t {logic [AW-1:0] addr; logic [DW-1:0] data;}.
- Sub-module rf_wb_fifo: 2-push/1-pop circular buffer with count, exposing its entry array, valid mask and head index for the forwarding search.
- Top level: push ordering, ready/ovf logic, output register, priority search for two lookups.

## Test plan

- Reset: assert rst = 0 for 2 cycles mid-stream with 3 entries queued -> WrX = 0, waddr = 0, DataIn = 0, ovf = 0, in_ready = 1, and no writes occur after release.
- Single write: alu_valid with r3 = 16'h1234 at edge N -> WrX = 1, waddr = 3, DataIn = 16'h1234 in cycle N+1 only; RF r3 reads 16'h1234 from N+2.
- Dual push ordering: mem r5 = 16'h0001 and alu r5 = 16'h0002 in the same cycle -> writes in consecutive cycles, 0001 then 0002; fwd_addr_1 = 5 returns 0002 until the last write completes.
- Backpressure/full: dual pushes on 3 consecutive cycles with DEPTH = 4 -> in_ready drops at count 3; a valid presented then sets ovf = 1 and is not written; queued writes drain in order.
- Forwarding miss/hit: queue r7 = 16'hbeef and look up fwd_addr_2 = 7 and fwd_addr_1 = 8 -> hit_2 = 1 with 16'hbeef, hit_1 = 0 with 0; hit_2 clears the cycle after its WrX cycle.
- Wrap-around: 20 alternating single/dual pushes -> RF write sequence matches the push order exactly, with no drops while in_ready = 1.
